// File: rtl/lstm_mem_pkg.sv
// Shared sizing and state encoding for the LSTM gate-memory weight loader.
package lstm_mem_pkg;

  localparam int RAM_WIDTH = 16;
  localparam int RAM_DEPTH = 400;
  localparam int RAM_ADDR  = 9;
  localparam int NUM_MEM   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FLUSH  = 3'd2,
    SNAP   = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/ld_addr_cnt.sv
// Address / memory-select wrap counter for the in-order weight fill.
// addr_cnt walks 0..RAM_DEPTH-1; on wrap mem_sel advances. last_word flags
// the final entry of the final memory.
module ld_addr_cnt #(
  parameter int RAM_DEPTH = lstm_mem_pkg::RAM_DEPTH,
  parameter int RAM_ADDR  = lstm_mem_pkg::RAM_ADDR,
  parameter int NUM_MEM   = lstm_mem_pkg::NUM_MEM,
  parameter int SEL_W     = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                step,
  output logic [RAM_ADDR-1:0] addr_cnt,
  output logic [SEL_W-1:0]    mem_sel,
  output logic                last_word
);
  import lstm_mem_pkg::*;

  localparam logic [RAM_ADDR-1:0] ADDR_LAST = RAM_ADDR'(RAM_DEPTH - 1);
  localparam logic [SEL_W-1:0]    SEL_LAST  = SEL_W'(NUM_MEM - 1);

  logic [RAM_ADDR-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  // Next count: clear wins, otherwise advance one word per step with wrap.
  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    if (clr) begin
      addr_d = '0;
      sel_d  = '0;
    end else if (step) begin
      if (addr_q == ADDR_LAST) begin
        addr_d = '0;
        sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      sel_q  <= '0;
    end else begin
      addr_q <= addr_d;
      sel_q  <= sel_d;
    end
  end

  assign addr_cnt  = addr_q;
  assign mem_sel   = sel_q;
  assign last_word = (addr_q == ADDR_LAST) && (sel_q == SEL_LAST);

endmodule

// File: rtl/weight_load_ctrl.sv
// Streams weights into NUM_MEM gate memories in order, then pulses a
// broadcast snapshot enable and reports completion.
//
//   state  | meaning
//   IDLE   | waiting for start (load + snapshot) or snap_req (snapshot only)
//   LOAD   | accepting stream words, one write presented per handshake
//   FLUSH  | final write of the last memory is on the write port
//   SNAP   | ce0 high for one cycle
//   SETTLE | memories' snapshot outputs update at the SNAP edge
//   DONE   | done pulse, back to IDLE
module weight_load_ctrl #(
  parameter int RAM_WIDTH = lstm_mem_pkg::RAM_WIDTH,
  parameter int RAM_DEPTH = lstm_mem_pkg::RAM_DEPTH,
  parameter int RAM_ADDR  = lstm_mem_pkg::RAM_ADDR,
  parameter int NUM_MEM   = lstm_mem_pkg::NUM_MEM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 snap_req,
  input  logic                 in_valid,
  input  logic [RAM_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic [NUM_MEM-1:0]   we1,
  output logic [NUM_MEM-1:0]   ce1,
  output logic [RAM_ADDR-1:0]  addr1,
  output logic [RAM_WIDTH-1:0] win,
  output logic                 ce0,
  output logic                 busy,
  output logic                 done
);
  import lstm_mem_pkg::*;

  localparam int SEL_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic [NUM_MEM-1:0]   we1_q, we1_d;
  logic [RAM_ADDR-1:0]  addr1_q, addr1_d;
  logic [RAM_WIDTH-1:0] win_q, win_d;
  logic                 ce0_q, ce0_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 hs;
  logic [RAM_ADDR-1:0]  addr_cnt;
  logic [SEL_W-1:0]     mem_sel;
  logic                 last_word;

  // in_ready_q is only ever high in LOAD, so a handshake implies LOAD.
  assign hs = in_valid && in_ready_q;

  ld_addr_cnt #(
    .RAM_DEPTH (RAM_DEPTH),
    .RAM_ADDR  (RAM_ADDR),
    .NUM_MEM   (NUM_MEM),
    .SEL_W     (SEL_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == IDLE),
    .step      (hs),
    .addr_cnt  (addr_cnt),
    .mem_sel   (mem_sel),
    .last_word (last_word)
  );

  // Next state and next registered outputs; status outputs decode the
  // upcoming state so they are valid for the whole cycle they describe.
  always_comb begin
    state_d = state_q;
    we1_d   = '0;
    addr1_d = addr1_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (start)         state_d = LOAD;
        else if (snap_req) state_d = SNAP;
      end
      LOAD:    if (hs && last_word) state_d = FLUSH;
      FLUSH:   state_d = SNAP;
      SNAP:    state_d = SETTLE;
      SETTLE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (hs) begin
      we1_d   = NUM_MEM'(1) << mem_sel;
      addr1_d = addr_cnt;
      win_d   = in_data;
    end
    in_ready_d = (state_d == LOAD);
    ce0_d      = (state_d == SNAP);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and output registers; reset overrides any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      we1_q      <= '0;
      addr1_q    <= '0;
      win_q      <= '0;
      ce0_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      we1_q      <= we1_d;
      addr1_q    <= addr1_d;
      win_q      <= win_d;
      ce0_q      <= ce0_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign we1      = we1_q;
  assign ce1      = we1_q;
  assign addr1    = addr1_q;
  assign win      = win_q;
  assign ce0      = ce0_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 Parameter RAM_WIDTH, default 16: weight word width.
REQ-002 Parameter RAM_DEPTH, default 400: entries per gate memory.
REQ-003 Parameter RAM_ADDR, default 9: address width; must satisfy 2^RAM_ADDR >= RAM_DEPTH.
REQ-004 Parameter NUM_MEM, default 4: number of gate memories served (i, f, g, o).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  in  1: single clock; all state updates on its rising edge.
REQ-007 rst  in  1: synchronous, active-high reset.
REQ-008 start  in  1: single-cycle request for a full load of all NUM_MEM memories, followed by a snapshot.
REQ-009 snap_req  in  1: single-cycle request for a snapshot only, with no load.
REQ-010 in_valid  in  1: weight stream word valid.
REQ-011 in_data  in  RAM_WIDTH: weight stream word.
REQ-012 in_ready  out  1: stream ready; a word transfers when in_valid && in_ready.
REQ-013 we1  out  NUM_MEM: one-hot per-memory write enable.
REQ-014 ce1  out  NUM_MEM: per-memory write-port enable; identical to we1.
REQ-015 addr1  out  RAM_ADDR: shared write address.
REQ-016 win  out  RAM_WIDTH: shared write data.
REQ-017 ce0  out  1: snapshot enable, broadcast to all memories.
REQ-018 busy  out  1: high in every state except IDLE.
REQ-019 done  out  1: one-cycle pulse when the snapshot outputs are valid.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, FLUSH, SNAP, SETTLE, DONE.
REQ-021 IDLE: start moves to LOAD; snap_req alone moves to SNAP; if both are high together, start wins.
REQ-022 start or snap_req received outside IDLE SHALL be ignored, with no queuing.
REQ-023 in_ready SHALL be 1 only in LOAD.
REQ-024 Each LOAD handshake SHALL register the write outputs for exactly the next cycle: win=in_data, addr1=addr_cnt, we1=ce1=(1<<mem_sel).
REQ-025 we1 and ce1 SHALL be 0 in any cycle that does not follow a handshake; addr1 and win hold their last value.
REQ-026 Counters: addr_cnt steps 0..RAM_DEPTH-1 per handshake; at RAM_DEPTH-1 it wraps to 0 and mem_sel increments. In-order fill: memory 0 first, address ascending.
REQ-027 A handshake at addr_cnt=RAM_DEPTH-1 with mem_sel=NUM_MEM-1 SHALL move LOAD to FLUSH; counters return to 0.
REQ-028 FLUSH: one cycle in which the final write is presented, then SNAP.
REQ-029 SNAP: ce0=1 for exactly one cycle, then SETTLE. ce0 SHALL be 0 in all other states.
REQ-030 SETTLE: one cycle (wout_all updates at the SNAP edge), then DONE.
REQ-031 DONE: done=1 for one cycle, then IDLE.
REQ-032 Latency: last handshake at edge T gives ce0 high in cycle T+2 and done high in cycle T+4. snap_req at edge T gives ce0 in T+1 and done in T+3.
REQ-033 LOAD with in_valid=0 SHALL stall with no writes, indefinitely; no timeout.
REQ-034 ce0 and any we1 bit SHALL never be high in the same cycle.

Reset
REQ-035 rst SHALL force: state=IDLE, addr_cnt=0, mem_sel=0, we1=ce1=0, addr1=0, win=0, ce0=0, in_ready=0, busy=0, done=0.
REQ-036 rst mid-LOAD SHALL abandon the load: no further writes, no snapshot, no done; memory contents already written are left unchanged.
REQ-037 rst has priority over start and snap_req in the same cycle.

Structure
REQ-038 RAM_WIDTH, RAM_DEPTH, RAM_ADDR, NUM_MEM and the state encoding SHALL live in shared package lstm_mem_pkg.
REQ-039 A single sub-module, ld_addr_cnt, SHALL provide the addr_cnt/mem_sel wrap counter with a last-word flag. Everything else is flat.

Verification
REQ-040 Full load: start, then 1600 back-to-back words with value k = word index. Required: we1=0001 for addr 0..399, then 0010, 0100, 1000; ce0 two cycles after the last handshake; done two cycles later; wout_all of memory 2 entry 5 = 805.
REQ-041 Backpressure: in_valid toggles randomly at 50%. Required: exactly 1600 writes, none duplicated or skipped, same final contents as REQ-040.
REQ-042 Snapshot only: snap_req in IDLE. Required: no we1 activity; ce0 next cycle; done 3 cycles after the request.
REQ-043 Collisions: start and snap_req in the same cycle enters LOAD. start asserted during LOAD at word 100 is ignored, and the word count stays at 1600.
REQ-044 Reset mid-load: rst after word 900. Required: all outputs at reset values next cycle; no ce0 or done; a following start restarts at memory 0, addr 0.
REQ-045 Boundary: word 399 to word 400 transition. Required: we1 changes from 0001 to 0010 and addr1 goes from 399 to 0 in consecutive write cycles.
